// File: rtl/fsb_bridge_if.sv
// rtl/fsb_bridge_if.sv - Wishbone-side and FSB pin-side signal bundle for fsb_bridge
interface fsb_bridge_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] WB_ADRi;
  logic [7:0]        WB_DATi;
  logic [7:0]        WB_DATo;
  logic              WB_WEi;
  logic              WB_CYCi;
  logic              WB_STBi;
  logic              WB_ACKo;
  logic [ADDR_W-1:0] FSB_ADDR;
  logic [7:0]        FSB_DQo;
  logic [7:0]        FSB_DQi;
  logic              FSB_DQoe;
  logic              FSB_CEn;
  logic              FSB_OEn;
  logic              FSB_WEn;
  logic              FSB_RDY;
  logic              FSB_TMO;

  modport slave (
    input  WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi, FSB_DQi, FSB_RDY,
    output WB_DATo, WB_ACKo, FSB_ADDR, FSB_DQo, FSB_DQoe, FSB_CEn, FSB_OEn,
           FSB_WEn, FSB_TMO
  );

  modport master (
    output WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi, FSB_DQi, FSB_RDY,
    input  WB_DATo, WB_ACKo, FSB_ADDR, FSB_DQo, FSB_DQoe, FSB_CEn, FSB_OEn,
           FSB_WEn, FSB_TMO
  );
endinterface

// File: rtl/fsb_bridge.sv
// rtl/fsb_bridge.sv - Wishbone classic slave to external FSB parallel bus bridge
module fsb_bridge #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SYNC_MODE,
  input  logic [6:0] ASYNC_WAITCYCLE,
  fsb_bridge_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_ACK} state_t;

  state_t            r_state;
  logic              r_we;
  logic              r_mode;
  logic [6:0]        r_wait;
  logic [6:0]        r_wcnt;
  logic [TW-1:0]     r_tcnt;
  logic [7:0]        r_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_dqo;
  logic [7:0]        r_dato;
  logic              r_ack;
  logic              r_dqoe;
  logic              r_cen;
  logic              r_oen;
  logic              r_wen;
  logic              r_tmo;

  logic              w_tmo_hit;
  logic              w_leave;
  logic [7:0]        w_cap;

  // Sync mode: a ready on the last allowed cycle still wins over the timeout.
  always_comb begin
    w_tmo_hit = r_mode && !bus.FSB_RDY && (r_tcnt == TLAST);
    w_leave   = r_mode ? (bus.FSB_RDY || w_tmo_hit) : (r_wcnt == r_wait);
    w_cap     = w_tmo_hit ? 8'hFF : bus.FSB_DQi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_mode  <= 1'b0;
      r_wait  <= 7'd0;
      r_wcnt  <= 7'd0;
      r_tcnt  <= '0;
      r_rdata <= 8'h00;
      r_addr  <= '0;
      r_dqo   <= 8'h00;
      r_dato  <= 8'h00;
      r_ack   <= 1'b0;
      r_dqoe  <= 1'b0;
      r_cen   <= 1'b1;
      r_oen   <= 1'b1;
      r_wen   <= 1'b1;
      r_tmo   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.WB_CYCi && bus.WB_STBi) begin
            r_addr  <= bus.WB_ADRi;
            r_dqo   <= bus.WB_DATi;
            r_we    <= bus.WB_WEi;
            r_mode  <= SYNC_MODE;
            r_wait  <= ASYNC_WAITCYCLE;
            r_cen   <= 1'b0;
            r_dqoe  <= bus.WB_WEi;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_oen   <= r_we;
          r_wen   <= !r_we;
          r_wcnt  <= 7'd0;
          r_tcnt  <= '0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_leave) begin
            r_rdata <= w_cap;
            r_oen   <= 1'b1;
            r_wen   <= 1'b1;
            r_state <= S_HOLD;
            if (w_tmo_hit) r_tmo <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + 7'd1;
            if (r_tcnt != '1) r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_HOLD: begin
          r_cen   <= 1'b1;
          r_dqoe  <= 1'b0;
          r_ack   <= bus.WB_CYCi;
          if (!r_we) r_dato <= r_rdata;
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.WB_DATo  = r_dato;
  assign bus.WB_ACKo  = r_ack;
  assign bus.FSB_ADDR = r_addr;
  assign bus.FSB_DQo  = r_dqo;
  assign bus.FSB_DQoe = r_dqoe;
  assign bus.FSB_CEn  = r_cen;
  assign bus.FSB_OEn  = r_oen;
  assign bus.FSB_WEn  = r_wen;
  assign bus.FSB_TMO  = r_tmo;
endmodule

// File: tb/tb_fsb_bridge.sv
// tb/tb_fsb_bridge.sv - randomized bench for fsb_bridge with a cycle-timeline reference model
module tb_fsb_bridge;
  localparam int TMO = 8;

  logic       clk;
  logic       rst;
  logic       sync_mode;
  logic [6:0] async_wait;
  int         cyc_cnt = 0;

  fsb_bridge_if #(.ADDR_W(16)) bus ();

  fsb_bridge #(.ADDR_W(16), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .SYNC_MODE       (sync_mode),
    .ASYNC_WAITCYCLE (async_wait),
    .bus             (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_cmp = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  logic        exp_cen, exp_oen, exp_wen, exp_dqoe, exp_ack, exp_tmo;
  logic [7:0]  exp_dato, exp_dqo;
  logic [15:0] exp_addr;

  int ack_cyc = -1, ack_n = 0, oen_lo = 0, wen_lo = 0, cen_lo = 0, dqoe_hi = 0;
  int t_start, s_ack, s_oen, s_wen, s_cen, s_dqoe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("cen", 32'(bus.FSB_CEn), 32'(exp_cen));
      chk("oen", 32'(bus.FSB_OEn), 32'(exp_oen));
      chk("wen", 32'(bus.FSB_WEn), 32'(exp_wen));
      chk("dqoe", 32'(bus.FSB_DQoe), 32'(exp_dqoe));
      chk("ack", 32'(bus.WB_ACKo), 32'(exp_ack));
      chk("dato", 32'(bus.WB_DATo), 32'(exp_dato));
      chk("tmo", 32'(bus.FSB_TMO), 32'(exp_tmo));
      if (!exp_cen) chk("addr", 32'(bus.FSB_ADDR), 32'(exp_addr));
      if (exp_dqoe) chk("dqo", 32'(bus.FSB_DQo), 32'(exp_dqo));
      if (bus.WB_ACKo === 1'b1) begin ack_cyc = cyc_cnt; ack_n++; end
      if (bus.FSB_OEn === 1'b0) oen_lo++;
      if (bus.FSB_WEn === 1'b0) wen_lo++;
      if (bus.FSB_CEn === 1'b0) cen_lo++;
      if (bus.FSB_DQoe === 1'b1) dqoe_hi++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle();
    exp_cen = 1'b1; exp_oen = 1'b1; exp_wen = 1'b1; exp_dqoe = 1'b0; exp_ack = 1'b0;
  endtask

  task automatic exp_reset();
    exp_idle();
    exp_dato = 8'h00; exp_tmo = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.WB_STBi = 1'b0;
      bus.WB_CYCi = 1'($urandom);
      bus.FSB_RDY = 1'($urandom);
      bus.FSB_DQi = 8'($urandom);
      step();
      exp_idle();
    end
  endtask

  // Access length L is w+1 (async) or the ready cycle / TIMEOUT (sync); the
  // external timeline is then SETUP at 1, ACCESS 2..L+1, HOLD L+2, ACK L+3.
  task automatic do_txn(input bit we, input logic [15:0] addr, input logic [7:0] data,
                        input bit mode, input logic [6:0] w, input int rdy_k,
                        input int drop_at, input int rst_at, input bit fix,
                        input logic [7:0] dqv);
    int L;
    bit tmo_hit, cyc_v, cyc_hold;
    logic [7:0] cap;
    tmo_hit = mode && !(rdy_k >= 1 && rdy_k <= TMO);
    L = !mode ? int'(w) + 1 : (tmo_hit ? TMO : rdy_k);
    cyc_hold = 1'b0;
    cap = 8'h00;
    t_start = cyc_cnt;
    s_ack = ack_n; s_oen = oen_lo; s_wen = wen_lo; s_cen = cen_lo; s_dqoe = dqoe_hi;
    bus.WB_CYCi = 1'b1; bus.WB_STBi = 1'b1; bus.WB_WEi = we;
    bus.WB_ADRi = addr; bus.WB_DATi = data;
    sync_mode = mode; async_wait = w;
    bus.FSB_RDY = 1'($urandom); bus.FSB_DQi = 8'($urandom);
    for (int o = 1; o <= L + 3; o++) begin
      step();
      exp_cen  = !(o <= L + 2);
      exp_oen  = !(!we && o >= 2 && o <= L + 1);
      exp_wen  = !(we && o >= 2 && o <= L + 1);
      exp_dqoe = we && (o <= L + 2);
      exp_addr = addr;
      exp_dqo  = data;
      exp_ack  = (o == L + 3) && cyc_hold;
      if (o == L + 2 && tmo_hit) exp_tmo = 1'b1;
      if (o == L + 3 && !we) exp_dato = cap;
      if (o == rst_at) begin
        rst = 1'b1;
        bus.WB_CYCi = 1'b0; bus.WB_STBi = 1'b0;
        step();
        rst = 1'b0;
        exp_reset();
        break;
      end
      cyc_v = !((drop_at > 0 && o >= drop_at) || o >= L + 3);
      if (o == L + 2) cyc_hold = cyc_v;
      bus.WB_CYCi = cyc_v; bus.WB_STBi = 1'b0;
      bus.WB_WEi = 1'($urandom); bus.WB_ADRi = 16'($urandom); bus.WB_DATi = 8'($urandom);
      sync_mode = !mode; async_wait = 7'($urandom);
      if (mode && o >= 2 && o <= L + 1) bus.FSB_RDY = (o - 1 == rdy_k);
      else bus.FSB_RDY = 1'($urandom);
      bus.FSB_DQi = fix ? dqv : 8'($urandom);
      if (o == L + 1) cap = tmo_hit ? 8'hFF : bus.FSB_DQi;
    end
    step();
    exp_idle();
  endtask

  initial begin
    bit rwe, rmode;
    logic [6:0] rw;
    rst = 1'b1; sync_mode = 1'b0; async_wait = 7'd0;
    bus.WB_CYCi = 1'b0; bus.WB_STBi = 1'b0; bus.WB_WEi = 1'b0;
    bus.WB_ADRi = 16'h0; bus.WB_DATi = 8'h0; bus.FSB_RDY = 1'b0; bus.FSB_DQi = 8'h0;
    exp_reset(); exp_addr = 16'h0; exp_dqo = 8'h0;
    step();
    check_en = 1'b1;
    step();
    chk("reset_addr", 32'(bus.FSB_ADDR), 32'h0);
    chk("reset_dqo", 32'(bus.FSB_DQo), 32'h0);
    rst = 1'b0;
    idle(2);

    do_txn(1'b0, 16'h1234, 8'h00, 1'b0, 7'd3, 0, 0, 0, 1'b1, 8'hA5);
    chk("t1_ack_latency", 32'(ack_cyc - t_start), 32'd7);
    chk("t1_dato", 32'(bus.WB_DATo), 32'hA5);
    chk("t1_oen_cycles", 32'(oen_lo - s_oen), 32'd4);
    idle(1);

    do_txn(1'b1, 16'h0010, 8'h3C, 1'b0, 7'd0, 0, 0, 0, 1'b0, 8'h00);
    chk("t2_ack_latency", 32'(ack_cyc - t_start), 32'd4);
    chk("t2_cen_cycles", 32'(cen_lo - s_cen), 32'd3);
    chk("t2_wen_cycles", 32'(wen_lo - s_wen), 32'd1);
    chk("t2_dqoe_cycles", 32'(dqoe_hi - s_dqoe), 32'd3);
    chk("t2_dato_kept", 32'(bus.WB_DATo), 32'hA5);

    do_txn(1'b0, 16'h4321, 8'h00, 1'b1, 7'd0, 5, 0, 0, 1'b1, 8'h5A);
    chk("t3_ack_latency", 32'(ack_cyc - t_start), 32'd8);
    chk("t3_dato", 32'(bus.WB_DATo), 32'h5A);
    chk("t3_tmo", 32'(bus.FSB_TMO), 32'd0);

    do_txn(1'b0, 16'h0BAD, 8'h00, 1'b1, 7'd0, 0, 0, 0, 1'b1, 8'h11);
    chk("t4_ack_latency", 32'(ack_cyc - t_start), 32'd11);
    chk("t4_dato", 32'(bus.WB_DATo), 32'hFF);
    chk("t4_tmo", 32'(bus.FSB_TMO), 32'd1);
    do_txn(1'b0, 16'h0001, 8'h00, 1'b1, 7'd0, 2, 0, 0, 1'b1, 8'h42);
    chk("t4_tmo_sticky", 32'(bus.FSB_TMO), 32'd1);
    chk("t4_good_dato", 32'(bus.WB_DATo), 32'h42);

    do_txn(1'b0, 16'h0F0F, 8'h00, 1'b0, 7'd2, 0, 0, 0, 1'b1, 8'hC3);
    chk("t5_oen_cycles", 32'(oen_lo - s_oen), 32'd3);
    chk("t5_ack_latency", 32'(ack_cyc - t_start), 32'd6);

    do_txn(1'b1, 16'h2222, 8'h99, 1'b0, 7'd5, 0, 0, 3, 1'b0, 8'h00);
    chk("t6_no_ack", 32'(ack_n - s_ack), 32'd0);
    chk("t6_tmo_cleared", 32'(bus.FSB_TMO), 32'd0);
    idle(1);
    do_txn(1'b0, 16'h3333, 8'h00, 1'b0, 7'd1, 0, 0, 0, 1'b1, 8'h77);
    chk("t6_fresh_latency", 32'(ack_cyc - t_start), 32'd5);
    chk("t6_fresh_dato", 32'(bus.WB_DATo), 32'h77);

    do_txn(1'b0, 16'h5555, 8'h00, 1'b0, 7'd2, 0, 3, 0, 1'b1, 8'h66);
    chk("t7_dropped_no_ack", 32'(ack_n - s_ack), 32'd0);

    for (int i = 0; i < 200; i++) begin
      rwe = 1'($urandom);
      rmode = 1'($urandom);
      rw = ($urandom_range(0, 9) == 0) ? 7'd127 : 7'($urandom_range(0, 4));
      do_txn(rwe, 16'($urandom), 8'($urandom), rmode, rw, int'($urandom_range(0, TMO + 2)),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : 0, 0, 1'b0, 8'h00);
      idle(int'($urandom_range(0, 2)));
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fsb_bridge.md
Name: fsb_bridge

Overview:
- Wishbone-slave to external front-side-bus (FSB) bridge. Consumes SYNC_MODE / ASYNC_WAITCYCLE from the system controller.
- Converts single 8-bit Wishbone classic cycles into one external parallel-bus access (CEn/OEn/WEn, tristate DQ).
- Two access modes:
  - Async: fixed programmable wait count.
  - Sync: ready-handshake, with a timeout.
- Sits between the CPU data-bus interconnect and the off-chip memory/peripheral pins.

Parameters:
ADDR_W, 16, width of Wishbone and FSB address
TIMEOUT, 255, max ACCESS cycles in sync mode before forced completion (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
SYNC_MODE  in  1  1=sync (FSB_RDY handshake), 0=async (wait count)
ASYNC_WAITCYCLE  in  7  extra ACCESS cycles in async mode
WB_ADRi  in  ADDR_W  Wishbone address
WB_DATi  in  8  Wishbone write data
WB_DATo  out  8  Wishbone read data
WB_WEi  in  1  write enable
WB_CYCi  in  1  cycle valid
WB_STBi  in  1  strobe
WB_ACKo  out  1  one-cycle acknowledge
FSB_ADDR  out  ADDR_W  external address
FSB_DQo  out  8  external write data
FSB_DQi  in  8  external read data (pre-synchronised by pad logic)
FSB_DQoe  out  1  DQ output enable, 1=drive
FSB_CEn  out  1  chip enable, active low
FSB_OEn  out  1  output enable, active low
FSB_WEn  out  1  write enable, active low
FSB_RDY  in  1  sync-mode ready, sampled on clk
FSB_TMO  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values:
  - State IDLE.
  - WB_ACKo=0, WB_DATo=8'h00.
  - FSB_CEn=FSB_OEn=FSB_WEn=1, FSB_DQoe=0, FSB_ADDR=0, FSB_DQo=0.
  - FSB_TMO=0.
  - All outputs are registered.
- rst asserted in any state: every output reaches its reset value at the next clk edge. The in-flight access is abandoned and no ACK is issued.
- States: IDLE, SETUP, ACCESS, HOLD, ACK.
- IDLE:
  - When WB_CYCi & WB_STBi are sampled high, latch WB_ADRi, WB_DATi and WB_WEi.
  - Latch mode m=SYNC_MODE and count w=ASYNC_WAITCYCLE.
  - Go to SETUP.
  - Changes to SYNC_MODE or ASYNC_WAITCYCLE after this point do not affect the current access.
- SETUP (1 cycle):
  - FSB_CEn=0; FSB_ADDR valid.
  - Write: FSB_DQoe=1, FSB_DQo=data.
  - FSB_OEn=FSB_WEn=1.
- ACCESS:
  - FSB_OEn=0 for reads, FSB_WEn=0 for writes. CEn, address and write data are held.
  - Async (m=0): remain exactly w+1 cycles (w=0 gives 1 cycle, w=127 gives 128). Read data is captured from FSB_DQi on the edge leaving ACCESS.
  - Sync (m=1): leave on the edge where FSB_RDY is sampled 1, capturing FSB_DQi for reads. FSB_RDY is ignored in all other states.
  - Sync timeout: if FSB_RDY is not seen within TIMEOUT cycles, leave anyway, capture read data as 8'hFF, and set FSB_TMO=1.
  - FSB_TMO clears only on rst.
- HOLD (1 cycle):
  - FSB_OEn=FSB_WEn=1.
  - FSB_CEn=0, address and write data are still held (hold time).
- ACK (1 cycle):
  - FSB_CEn=1, FSB_DQoe=0.
  - WB_ACKo=1 only if WB_CYCi is still 1. If the master dropped CYC mid-access, the external access still completes but the ACK is suppressed.
  - WB_DATo=captured data (reads). WB_DATo is unchanged on writes.
  - Next state is IDLE.
- Latency: with the request sampled in cycle 0, async ACK is high in cycle w+4.
- Back-to-back: if STB is still high in IDLE right after ACK, a new access starts (classic Wishbone; the master must deassert STB after ACK to avoid a repeat).
- Counter widths:
  - Wait counter: 7 bits.
  - Timeout counter: ceil(log2(TIMEOUT+1)) bits, saturating, cleared on entry to ACCESS.
- Signal exclusivity: FSB_OEn and FSB_WEn are never simultaneously 0. DQoe is never 1 during a read.

Test Plan:
- Async read, w=3, addr 16'h1234, FSB_DQi=8'hA5 → OEn low for 4 cycles, ACK in cycle 7, WB_DATo=8'hA5.
- Async write, w=0, addr 16'h0010, data 8'h3C → CEn low in cycles 1-3, WEn low in cycle 2 only, DQoe 1 in cycles 1-3, DQo=8'h3C, ACK in cycle 4.
- Sync read, FSB_RDY rises in the 5th ACCESS cycle with DQi=8'h5A → ACK 2 cycles later, WB_DATo=8'h5A, FSB_TMO=0.
- Sync read, TIMEOUT=8, FSB_RDY held at 0 → exits ACCESS after 8 cycles, WB_DATo=8'hFF, FSB_TMO=1 and still 1 on the next good access.
- Mode/count change mid-access: start async w=2, then flip SYNC_MODE=1 and ASYNC_WAITCYCLE=7'h7F during ACCESS → access still completes with 3 ACCESS cycles.
- rst pulsed in ACCESS of a write → next edge: CEn/WEn=1, DQoe=0, no ACK. A fresh read afterwards completes normally.
